// File: rtl/spi_target_regs_pkg.sv
// ---------------------------------------------------------------------------
// spi_target_pkg
// Shared types and constants for the SPI mode-0 register target.
//   state_t   : transaction state (IDLE, CMD, DATA)
//   dbg_t     : debug snapshot of the target's internal state
//   reg_read  : returns the byte the target would shift out for an address
// ---------------------------------------------------------------------------
package spi_target_pkg;

  localparam int ADDR_W      = 4;
  localparam int CMD_RW_BIT  = 7;
  localparam int NUM_CTRL    = 8;
  localparam int NUM_STATUS  = 8;
  localparam int STATUS_BASE = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    DATA = 2'd2
  } state_t;

  typedef struct packed {
    state_t              state;
    logic [2:0]          bit_cnt;
    logic [ADDR_W-1:0]   addr;
    logic                rd;
    logic                sclk_q;
    logic                ss_n_q;
  } dbg_t;

  // Byte idx of a 64-bit little-endian byte vector.
  function automatic logic [7:0] byte_sel(input logic [63:0] v,
                                          input logic [2:0]  idx);
    byte_sel = v[{idx, 3'b000} +: 8];
  endfunction

  // Addresses 0..7 are control bytes, 8..15 are status bytes; the
  // status window starts at STATUS_BASE = 8, so bit 3 selects it.
  function automatic logic [7:0] reg_read(input logic [ADDR_W-1:0]     addr,
                                          input logic [NUM_CTRL*8-1:0]   ctrl,
                                          input logic [NUM_STATUS*8-1:0] status);
    if (addr[3]) reg_read = byte_sel(status, addr[2:0]);
    else         reg_read = byte_sel(ctrl, addr[2:0]);
  endfunction

endpackage

// File: rtl/spi_target_regs_if.sv
// ---------------------------------------------------------------------------
// spi_target_regs_if
// SPI pin bundle between the SoC SPI master (spi_0) and the fabric target.
//   spi_sclk    : serial clock, idle low (CPOL=0)
//   spi_mosi    : master-out data, MSB first, changes on SCLK fall
//   spi_ss_n    : active-low select, framing one transaction
//   spi_miso    : target-out data, 0 when not selected
//   spi_miso_oe : target output enable, high while selected
// Transfer semantics: there is no valid/ready pair on this bus. A bit is
// valid on MOSI/MISO at every SCLK rise while SS_n is low; the target can
// never stall the master, so the master alone paces every transfer.
// ---------------------------------------------------------------------------
interface spi_target_regs_if;
  logic spi_sclk;
  logic spi_mosi;
  logic spi_ss_n;
  logic spi_miso;
  logic spi_miso_oe;

  modport master (
    output spi_sclk, spi_mosi, spi_ss_n,
    input  spi_miso, spi_miso_oe
  );

  modport slave (
    input  spi_sclk, spi_mosi, spi_ss_n,
    output spi_miso, spi_miso_oe
  );
endinterface

// File: rtl/spi_target_regs_sync_edge.sv
// ---------------------------------------------------------------------------
// spi_sync_edge
// Multi-flop synchronizer for an asynchronous pin, followed by one more
// register that serves as the synchronized level and as the reference for
// edge detection. Output level and edge pulses all appear STAGES+1 clocks
// after the pin changes.
//   clk, reset : system clock, async active-high reset
//   i_d        : asynchronous input pin
//   o_q        : synchronized, registered level
//   o_rise     : one-cycle pulse on a 0->1 transition
//   o_fall     : one-cycle pulse on a 1->0 transition
// Parameters: STAGES (>= 2, smaller values are raised to 2), RESET_VAL.
// ---------------------------------------------------------------------------
module spi_sync_edge #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic i_d,
  output logic o_q,
  output logic o_rise,
  output logic o_fall
);

  localparam int N = (STAGES < 2) ? 2 : STAGES;

  logic [N-1:0] r_sync;
  logic         r_q;
  logic         r_rise;
  logic         r_fall;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync <= {N{RESET_VAL}};
      r_q    <= RESET_VAL;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_sync <= {r_sync[N-2:0], i_d};
      r_q    <= r_sync[N-1];
      // Pulses are registered alongside r_q so level and edge line up.
      r_rise <=  r_sync[N-1] & ~r_q;
      r_fall <= ~r_sync[N-1] &  r_q;
    end
  end

  assign o_q    = r_q;
  assign o_rise = r_rise;
  assign o_fall = r_fall;

endmodule

// File: rtl/spi_target_regs.sv
// ---------------------------------------------------------------------------
// spi_target_regs
// SPI mode-0 target exposing eight R/W control bytes (addresses 0..7) and
// eight read-only status bytes (addresses 8..15) to the SoC SPI master.
// Transaction: command byte (bit 7 = read, bits 3:0 = start address), then
// data bytes until SS_n rises.
//
// Ports:
//   clk, reset   : system clock (>= 8x SCLK), async active-high reset
//   spi          : SPI pins (slave modport of spi_target_regs_if)
//   status_in    : status bytes, register 8+k = status_in[8k+7:8k]
//   ctrl_out     : control bytes, register k = ctrl_out[8k+7:8k]
//   wr_strobe    : one-cycle pulse when a control byte is written
//   wr_addr      : address of that byte, valid with wr_strobe
//   busy         : synchronized select active
//   o_dbg        : internal state snapshot (FSM state, bit count, address)
//
// Build option: define SPI_TARGET_AUTOINC_EN to advance the address by one
// after each data byte (wrapping 15 -> 0). Without it the address stays at
// the command's start address for the whole transaction.
// ---------------------------------------------------------------------------
module spi_target_regs
  import spi_target_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  spi_target_regs_if.slave      spi,
  input  logic [NUM_STATUS*8-1:0] status_in,
  output logic [NUM_CTRL*8-1:0] ctrl_out,
  output logic                  wr_strobe,
  output logic [2:0]            wr_addr,
  output logic                  busy,
  output dbg_t                  o_dbg
);

  localparam int SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  // ---------------- pin synchronization ----------------
  logic w_sclk_q, w_sclk_rise, w_sclk_fall;
  logic w_ss_q, w_ss_rise, w_ss_fall;
  logic w_mosi;

  spi_sync_edge #(
    .STAGES    (SYNC_N),
    .RESET_VAL (1'b0)
  ) u_sclk_sync (
    .clk    (clk),
    .reset  (reset),
    .i_d    (spi.spi_sclk),
    .o_q    (w_sclk_q),
    .o_rise (w_sclk_rise),
    .o_fall (w_sclk_fall)
  );

  // SS_n resets to the "selected" level so that a select held low across
  // reset produces no fall pulse: the target waits for a genuinely new
  // transaction. If the pin is high, the resulting rise pulse is harmless.
  spi_sync_edge #(
    .STAGES    (SYNC_N),
    .RESET_VAL (1'b0)
  ) u_ss_sync (
    .clk    (clk),
    .reset  (reset),
    .i_d    (spi.spi_ss_n),
    .o_q    (w_ss_q),
    .o_rise (w_ss_rise),
    .o_fall (w_ss_fall)
  );

  // MOSI needs no edge detection; one extra flop keeps it aligned with
  // the SCLK rise pulse so the sampled bit is the one present at the rise.
  logic [SYNC_N:0] r_mosi_sync;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_mosi_sync <= '0;
    else       r_mosi_sync <= {r_mosi_sync[SYNC_N-1:0], spi.spi_mosi};
  end

  assign w_mosi = r_mosi_sync[SYNC_N];

  // ---------------- FSM ----------------
  state_t r_state;
  state_t w_state_nxt;

  logic [2:0]          r_bit_cnt;
  logic [6:0]          r_rx;
  logic [7:0]          r_tx;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_rd;
  logic [NUM_CTRL*8-1:0] r_ctrl;
  logic                r_wr_strobe;
  logic [2:0]          r_wr_addr;

  logic                w_byte_done;
  logic [7:0]          w_rx_byte;
  logic [ADDR_W-1:0]   w_addr_nxt;
  logic                w_ctrl_hit;
  logic [7:0]          w_load_cmd;
  logic [7:0]          w_load_data;
  logic                w_busy;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_byte_done = (r_state != IDLE) && w_sclk_rise && (r_bit_cnt == 3'd7);
    // Select edges override everything: a rise aborts any partial byte.
    if (w_ss_rise) begin
      w_state_nxt = IDLE;
    end else if (w_ss_fall) begin
      w_state_nxt = CMD;
    end else begin
      case (r_state)
        CMD:     if (w_byte_done) w_state_nxt = DATA;
        default: w_state_nxt = r_state;
      endcase
    end
  end

  // ---------------- datapath helpers ----------------
  always_comb begin
    w_rx_byte   = {r_rx, w_mosi};
`ifdef SPI_TARGET_AUTOINC_EN
    w_addr_nxt  = r_addr + ADDR_W'(1);
`else
    w_addr_nxt  = r_addr;
`endif
    w_ctrl_hit  = (r_addr < ADDR_W'(STATUS_BASE));
    // A write command leaves the shifter at zero so MISO stays low.
    w_load_cmd  = w_rx_byte[CMD_RW_BIT] ?
                  reg_read(w_rx_byte[ADDR_W-1:0], r_ctrl, status_in) : 8'h00;
    // The next byte out comes from the address after this byte's advance.
    w_load_data = reg_read(w_addr_nxt, r_ctrl, status_in);
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bit_cnt   <= 3'd0;
      r_rx        <= 7'd0;
      r_tx        <= 8'h00;
      r_addr      <= '0;
      r_rd        <= 1'b0;
      r_ctrl      <= '0;
      r_wr_strobe <= 1'b0;
      r_wr_addr   <= 3'd0;
    end else begin
      r_wr_strobe <= 1'b0;
      if (w_ss_rise) begin
        r_bit_cnt <= 3'd0;
        r_tx      <= 8'h00;
      end else if (w_ss_fall) begin
        r_bit_cnt <= 3'd0;
        r_rx      <= 7'd0;
        r_tx      <= 8'h00;
        r_addr    <= '0;
        r_rd      <= 1'b0;
      end else if (r_state != IDLE) begin
        if (w_sclk_rise) begin
          r_rx      <= w_rx_byte[6:0];
          r_bit_cnt <= r_bit_cnt + 3'd1;
          if (w_byte_done) begin
            if (r_state == CMD) begin
              r_rd   <= w_rx_byte[CMD_RW_BIT];
              r_addr <= w_rx_byte[ADDR_W-1:0];
              r_tx   <= w_load_cmd;
            end else begin
              if (!r_rd && w_ctrl_hit) begin
                r_ctrl[{r_addr[2:0], 3'b000} +: 8] <= w_rx_byte;
                r_wr_strobe <= 1'b1;
                r_wr_addr   <= r_addr[2:0];
              end
              r_addr <= w_addr_nxt;
              if (r_rd) r_tx <= w_load_data;
            end
          end
        end else if (w_sclk_fall && (r_bit_cnt != 3'd0)) begin
          // The fall right after a byte boundary (count 0) is skipped so
          // bit 7 of a freshly loaded byte stays on MISO until sampled.
          r_tx <= {r_tx[6:0], 1'b0};
        end
      end
    end
  end

  // ---------------- outputs ----------------
  // Gating with the synchronized level drops busy/MISO one clock earlier
  // than the state register would, right when SS_n is seen high.
  assign w_busy          = (r_state != IDLE) && !w_ss_q;
  assign busy            = w_busy;
  assign spi.spi_miso_oe = w_busy;
  assign spi.spi_miso    = w_busy & r_tx[7];
  assign ctrl_out        = r_ctrl;
  assign wr_strobe       = r_wr_strobe;
  assign wr_addr         = r_wr_addr;

  always_comb begin
    o_dbg         = '0;
    o_dbg.state   = r_state;
    o_dbg.bit_cnt = r_bit_cnt;
    o_dbg.addr    = r_addr;
    o_dbg.rd      = r_rd;
    o_dbg.sclk_q  = w_sclk_q;
    o_dbg.ss_n_q  = w_ss_q;
  end

endmodule

// File: tb/tb_spi_target_regs.sv
module tb_spi_target_regs;
  import spi_target_pkg::*;

  localparam int SYNC = 2;
  localparam int HALF = 6;
`ifdef SPI_TARGET_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] status_in;
  logic [63:0] ctrl_out;
  logic        wr_strobe;
  logic [2:0]  wr_addr;
  logic        busy;
  dbg_t        dbg;

  always #10 clk = ~clk;

  spi_target_regs_if spi_if ();

  spi_target_regs #(.SYNC_STAGES(SYNC)) dut (
    .clk       (clk),
    .reset     (reset),
    .spi       (spi_if),
    .status_in (status_in),
    .ctrl_out  (ctrl_out),
    .wr_strobe (wr_strobe),
    .wr_addr   (wr_addr),
    .busy      (busy),
    .o_dbg     (dbg)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_errors = 0;

  logic [7:0]  ctrl_m [8];
  logic [7:0]  exp_rd_q [$];
  logic [66:0] exp_wr_q [$];
  logic [7:0]  data_q [$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] ctrl_pack();
    logic [63:0] v;
    for (int i = 0; i < 8; i++) v[i*8 +: 8] = ctrl_m[i];
    return v;
  endfunction

  function automatic logic [7:0] model_read(input int a);
    if (a < 8) return ctrl_m[a];
    return status_in[(a-8)*8 +: 8];
  endfunction

  // ---------------- driver tasks ----------------
  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic spi_bit(input logic b);
    spi_if.spi_mosi = b;
    wait_clks(HALF);
    spi_if.spi_sclk = 1'b1;
    wait_clks(HALF);
    spi_if.spi_sclk = 1'b0;
  endtask

  task automatic spi_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) spi_bit(b[i]);
  endtask

  task automatic ss_open();
    spi_if.spi_ss_n = 1'b0;
    wait_clks(HALF);
    @(negedge clk);
    check("busy_open", 128'(busy), 128'(1'b1));
    check("oe_open", 128'(spi_if.spi_miso_oe), 128'(1'b1));
  endtask

  task automatic ss_close();
    wait_clks(HALF);
    spi_if.spi_ss_n = 1'b1;
    // busy/oe/miso must drop SYNC+1 clocks after the SS_n rise
    wait_clks(SYNC + 1);
    @(negedge clk);
    check("busy_close", 128'(busy), 128'(1'b0));
    check("oe_close", 128'(spi_if.spi_miso_oe), 128'(1'b0));
    check("miso_close", 128'(spi_if.spi_miso), 128'(1'b0));
    wait_clks(HALF);
    check("ctrl_out", 128'(ctrl_out), 128'(ctrl_pack()));
    check("rd_q_drained", 128'(exp_rd_q.size()), 128'(0));
    check("wr_q_drained", 128'(exp_wr_q.size()), 128'(0));
    exp_rd_q.delete();
    exp_wr_q.delete();
  endtask

  // Full transaction: command then every byte in data_q. Expectations come
  // from the register-map rules applied to the byte-level model.
  task automatic xfer(input logic [7:0] cmd);
    int   a;
    logic rd;
    a  = int'(cmd[3:0]);
    rd = cmd[7];
    exp_rd_q.push_back(8'h00);
    foreach (data_q[i]) begin
      if (rd) begin
        exp_rd_q.push_back(model_read(a));
      end else begin
        exp_rd_q.push_back(8'h00);
        if (a < 8) begin
          ctrl_m[a] = data_q[i];
          exp_wr_q.push_back({3'(a), ctrl_pack()});
        end
      end
      if (AUTOINC) a = (a + 1) % 16;
    end
    ss_open();
    spi_byte(cmd);
    foreach (data_q[i]) spi_byte(data_q[i]);
    ss_close();
  endtask

  task automatic chk_reset(input string tag);
    check({tag, "_ctrl_out"}, 128'(ctrl_out), 128'(64'h0));
    check({tag, "_miso"}, 128'(spi_if.spi_miso), 128'(1'b0));
    check({tag, "_miso_oe"}, 128'(spi_if.spi_miso_oe), 128'(1'b0));
    check({tag, "_wr_strobe"}, 128'(wr_strobe), 128'(1'b0));
    check({tag, "_wr_addr"}, 128'(wr_addr), 128'(3'd0));
    check({tag, "_busy"}, 128'(busy), 128'(1'b0));
    check({tag, "_state"}, 128'(dbg.state), 128'(IDLE));
    check({tag, "_bit_cnt"}, 128'(dbg.bit_cnt), 128'(3'd0));
  endtask

  // ---------------- monitors ----------------
  // MISO monitor: master-side capture of each complete byte.
  initial begin : rd_mon
    logic [7:0] sh;
    int         nb;
    logic       prev;
    sh = 8'h00; nb = 0; prev = 1'b0;
    forever begin
      @(negedge clk);
      if (reset || spi_if.spi_ss_n) begin
        nb = 0;
      end else if (spi_if.spi_sclk && !prev) begin
        sh = {sh[6:0], spi_if.spi_miso};
        nb++;
        if (nb == 8) begin
          nb = 0;
          if (exp_rd_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL miso_unexpected: got byte %0h expected none", sh);
          end else begin
            check("miso_byte", 128'(sh), 128'(exp_rd_q.pop_front()));
          end
        end
      end
      prev = spi_if.spi_sclk;
    end
  end

  // Write monitor: every strobe must match the next expected write.
  initial begin : wr_mon
    forever begin
      @(negedge clk);
      if (!reset && wr_strobe) begin
        if (exp_wr_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL wr_unexpected: got strobe addr %0d expected none", wr_addr);
        end else begin
          check("wr_event", 128'({wr_addr, ctrl_out}), 128'(exp_wr_q.pop_front()));
        end
      end
    end
  end

  initial begin : watchdog
    #(50_000_000);
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- main stimulus ----------------
  initial begin : main
    logic [7:0] cmd;
    int         n;
    reset           = 1'b1;
    status_in       = 64'h0;
    spi_if.spi_ss_n = 1'b1;
    spi_if.spi_sclk = 1'b0;
    spi_if.spi_mosi = 1'b0;
    for (int i = 0; i < 8; i++) ctrl_m[i] = 8'h00;
    wait_clks(5);
    @(negedge clk);
    chk_reset("por");
    reset = 1'b0;
    wait_clks(8);

    // single write to register 3
    data_q.delete(); data_q.push_back(8'hA5);
    xfer(8'h03);

    // read burst from the status window
    status_in = {$urandom, $urandom};
    status_in[15:0] = 16'hC35A;
    data_q.delete(); data_q.push_back(8'hFF); data_q.push_back(8'h00);
    xfer(8'h88);

    // write at 15 then wrap to 0
    data_q.delete(); data_q.push_back(8'h11); data_q.push_back(8'h22);
    xfer(8'h0F);

    // abort mid-byte, then a normal transaction
    exp_rd_q.push_back(8'h00);
    ss_open();
    spi_byte(8'h02);
    for (int i = 0; i < 5; i++) spi_bit(1'b1);
    ss_close();
    data_q.delete(); data_q.push_back(8'h3C);
    xfer(8'h02);

    // randomized transactions
    repeat (16) begin
      status_in = {$urandom, $urandom};
      cmd = 8'($urandom_range(0, 255));
      n   = $urandom_range(1, 4);
      data_q.delete();
      for (int i = 0; i < n; i++) data_q.push_back(8'($urandom_range(0, 255)));
      xfer(cmd);
    end

    // reset during the second data byte
    exp_rd_q.push_back(8'h00);
    exp_rd_q.push_back(8'h00);
    ctrl_m[4] = 8'h99;
    exp_wr_q.push_back({3'd4, ctrl_pack()});
    ss_open();
    spi_byte(8'h04);
    spi_byte(8'h99);
    for (int i = 0; i < 3; i++) spi_bit(1'b1);
    reset = 1'b1;
    wait_clks(2);
    @(negedge clk);
    chk_reset("mid");
    reset = 1'b0;
    for (int i = 0; i < 8; i++) ctrl_m[i] = 8'h00;
    for (int i = 0; i < 5; i++) spi_bit(1'b0);
    ss_close();
    data_q.delete(); data_q.push_back(8'h7E);
    xfer(8'h01);

    // read back the whole map
    status_in = {$urandom, $urandom};
    for (int a = 0; a < 16; a++) begin
      data_q.delete(); data_q.push_back(8'($urandom_range(0, 255)));
      xfer(8'h80 | 8'(a));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/spi_target_regs.md
# spi_target_regs

SPI mode-0 target (responder) in FPGA fabric that answers the SoC's on-chip SPI master (`spi_0`). It exposes eight read/write control bytes to fabric logic and eight read-only status bytes sampled from fabric, so Nios software can configure and poll game hardware over the existing SPI pins without new Avalon peripherals. The block sits at the top level, between the `spi_0_*` SoC ports and the game logic.

## Interface
- `SYNC_STAGES`, 2: flip-flops in each SCLK/MOSI/SS_n synchronizer (minimum 2).
- `clk` in 1: system clock, 50 MHz; must be at least 8× the SCLK frequency.
- `reset` in 1: asynchronous, active-high reset.
- `spi_sclk` in 1: SPI clock from master, idle low (CPOL=0).
- `spi_mosi` in 1: master-out data, MSB first.
- `spi_ss_n` in 1: active-low select.
- `spi_miso` out 1: target-out data; 0 when not selected.
- `spi_miso_oe` out 1: high while selected, after synchronization.
- `status_in` in 64: read-only registers 8..15; register 8+k = `status_in[8k+7:8k]`.
- `ctrl_out` out 64: registers 0..7; register k = `ctrl_out[8k+7:8k]`.
- `wr_strobe` out 1: one-cycle pulse when a control byte is written.
- `wr_addr` out 3: address of the byte just written; valid with `wr_strobe`.
- `busy` out 1: synchronized select active.

## Operation
- Inputs are synchronized, then edge-detected. MOSI is sampled on the SCLK rise; MISO shifts on the SCLK fall.
- Transaction layout: command byte, then data bytes until SS_n rises.
  - Command bit 7 = 1 selects read, 0 selects write; bits 6:4 are ignored; bits 3:0 are the start address.
- States:
  - IDLE → CMD when SS_n falls.
  - CMD → DATA after the 8th rise.
  - Any state → IDLE when SS_n rises.
- Bit counter counts rises modulo 8. A falling edge shifts MISO only when the counter ≠ 0, so bit 7 of a loaded byte is held through the byte-boundary fall.
- Read:
  - At each byte completion in DATA, or at the end of CMD, the tx shifter loads the register at the current address. Status bytes are snapshotted at that cycle.
  - MISO drives 0 throughout the command byte.
- Write:
  - Each completed data byte goes to the current address.
  - Addresses 0..7 update `ctrl_out` and pulse `wr_strobe`.
  - Addresses 8..15 are silently discarded; no strobe is issued.
- Address advances by 1 after every data byte and wraps from 15 to 0.
- SS_n rising mid-byte: the partial byte is discarded, with no write and no strobe. The bit counter is cleared.
- Reset values:
  - `ctrl_out` = 0, `spi_miso` = 0, `spi_miso_oe` = 0.
  - `wr_strobe` = 0, `wr_addr` = 0, `busy` = 0.
  - State is IDLE. Reset mid-transaction aborts the transaction; the target waits for a fresh SS_n fall.

## Timing
- Pin edge to internal edge pulse: `SYNC_STAGES` + 1 clk.
- 8th MOSI rise → `ctrl_out` update and `wr_strobe` high: `SYNC_STAGES` + 2 clk. Both change in the same cycle.
- 8th rise → `spi_miso` shows bit 7 of the loaded byte: `SYNC_STAGES` + 2 clk. This is well before the next rise given the ≥8× clock ratio.
- SCLK fall → MISO change: `SYNC_STAGES` + 2 clk.
- SS_n rise → `busy`/`spi_miso_oe` low, `spi_miso` = 0: `SYNC_STAGES` + 1 clk.

## Configuration
- `SPI_TARGET_AUTOINC_EN`:
  - Defined: address auto-increments per data byte with 15→0 wrap, as described above.
  - Undefined: address stays fixed for the whole transaction. Repeated reads return fresh snapshots of the same register; repeated writes overwrite it, with one strobe per byte.

## Structure
- `spi_target_pkg`:
  - state enum (IDLE, CMD, DATA);
  - `CMD_RW_BIT` = 7;
  - `NUM_CTRL` = 8, `NUM_STATUS` = 8;
  - `STATUS_BASE` = 8;
  - address width 4.
- Sub-module `spi_sync_edge`: parameterized synchronizer with registered output plus rise/fall pulse outputs. Instantiated for SCLK and SS_n; MOSI uses the synchronizer only.

## Test plan
- Write: SS_n low, send 0x03 then 0xA5 → `ctrl_out[31:24]` = 0xA5, a single `wr_strobe` with `wr_addr` = 3; all other bytes stay 0.
- Read burst: `status_in[15:0]` = 0xC35A, send 0x88 followed by two dummy bytes → MISO returns 0x5A then 0xC3; MISO is 0 during the command byte.
- Wrap and read-only: send 0x0F, 0x11, 0x22 → address 15 is discarded with no strobe; register 0 = 0x22 with `wr_strobe` and `wr_addr` = 0. Without `SPI_TARGET_AUTOINC_EN`, both bytes are discarded.
- Abort: send 0x02, then 5 bits of 0xFF, then raise SS_n → no strobe, `ctrl_out` unchanged. The next full transaction works normally.
- Reset mid-burst: assert `reset` during the second data byte → all outputs return to reset values. A subsequent write of 0x01, 0x7E sets register 1 = 0x7E.
